alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares one combinational ALU (same 3-bit `alucont` encoding as the core datapath) between independent clients, such as the main datapath and a coprocessor or debug port. It accepts one operation at a time over a valid/ready handshake and registers the operands. It runs them through the ALU and returns a registered result, zero flag and error flag to the requester that issued the operation. Grants alternate round-robin so neither requester starves.

---
 rtl/alu_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that time-shares one combinational
// ALU between two requesters. One operation is in flight at a time: the
// operands are latched on the request handshake, executed in EXEC, and the
// registered result is held in RESP until the owning requester consumes it.
`timescale 1ns/1ps

module alu_share_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [N-1:0] req_a0,
   input  logic [N-1:0] req_b0,
   input  logic [N-1:0] req_a1,
   input  logic [N-1:0] req_b1,
   input  logic [2:0]   req_op0,
   input  logic [2:0]   req_op1,
   output logic [1:0]   resp_valid,
   input  logic [1:0]   resp_ready,
   output logic [N-1:0] resp_result,
   output logic         resp_zero,
   output logic         resp_err,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           prio_q, prio_d;
   logic           owner_q, owner_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [2:0]     op_q, op_d;
   logic [N-1:0]   result_q, result_d;
   logic           zero_q, zero_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;

   logic           grant;
   logic [N-1:0]   alu_result;
   logic           alu_err;

   // Pick the requester to serve: a lone requester wins, a tie goes to prio.
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      grant     = prio_q;
      req_ready = 2'b00;
      if (req_valid == 2'b01) begin
         grant = 1'b0;
      end else if (req_valid == 2'b10) begin
         grant = 1'b1;
      end
      if (state_q == ST_IDLE && req_valid != 2'b00) begin
         req_ready = grant ? 2'b10 : 2'b01;
      end
   end

   // Shared ALU, fed only from the latched operand registers.
   always_comb begin
      alu_result = '0;
      alu_err    = 1'b0;
      unique case (op_q)
         3'b000:  alu_result = a_q & b_q;
         3'b001:  alu_result = a_q | b_q;
         3'b010:  alu_result = a_q + b_q;
         3'b100:  alu_result = a_q & ~b_q;
         3'b101:  alu_result = a_q | ~b_q;
         3'b110:  alu_result = a_q - b_q;
         3'b111:  alu_result = {{(N-1){1'b0}}, (a_q < b_q)};
         default: alu_err    = 1'b1;   // 011 is not a legal alucont code
      endcase
   end

   // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      owner_d  = owner_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               a_d     = grant ? req_a1  : req_a0;
               b_d     = grant ? req_b1  : req_b0;
               op_d    = grant ? req_op1 : req_op0;
               owner_d = grant;
               prio_d  = ~grant;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = alu_result;
            zero_d   = (alu_result == '0);
            err_d    = alu_err;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset drops any in-flight operation.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   // Response strobe is decoded from the state register, so reset clears it at once.
   always_comb begin
      resp_valid = 2'b00;
      if (state_q == ST_RESP) begin
         resp_valid = owner_q ? 2'b10 : 2'b01;
      end
   end

   assign resp_result = result_q;
   assign resp_zero   = zero_q;
   assign resp_err    = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: per-requester stimulus queues,
// a cycle model of grant/state, and a scoreboard of expected responses.
`timescale 1ns/1ps

module tb_alu_share_arbiter;

   localparam int N = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ILL  = 3'b011;
   localparam logic [2:0] OP_RAND = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   op;
   } op_t;

   typedef struct packed {
      logic [N-1:0] result;
      logic         zero;
      logic         err;
   } exp_t;

   typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_t;

   logic         clk;
   logic         resetn;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [2:0]   req_op0, req_op1;
   logic [1:0]   resp_valid;
   logic [1:0]   resp_ready;
   logic [N-1:0] resp_result;
   logic         resp_zero;
   logic         resp_err;
   logic         busy;

   alu_share_arbiter #(.N(N)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a0      (req_a0),
      .req_b0      (req_b0),
      .req_a1      (req_a1),
      .req_b1      (req_b1),
      .req_op0     (req_op0),
      .req_op1     (req_op1),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_zero   (resp_zero),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   op_t     q0[$];
   op_t     q1[$];
   exp_t    sb[$];
   int      grants[$];
   mstate_t m_state    = M_IDLE;
   logic    m_prio     = 1'b0;
   logic    m_owner    = 1'b0;
   int      stall_left = 0;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic op_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
      op_t o;
      o.a  = a;
      o.b  = b;
      o.op = op;
      return o;
   endfunction

   function automatic exp_t alu_model(input op_t o);
      exp_t e;
      e.err    = 1'b0;
      e.result = '0;
      case (o.op)
         OP_AND:  e.result = o.a & o.b;
         OP_OR:   e.result = o.a | o.b;
         OP_ADD:  e.result = o.a + o.b;
         OP_RAND: e.result = o.a & ~o.b;
         OP_ROR:  e.result = o.a | ~o.b;
         OP_SUB:  e.result = o.a - o.b;
         OP_SLT:  e.result = (o.a < o.b) ? 32'd1 : 32'd0;
         default: e.err    = 1'b1;
      endcase
      e.zero = (e.result == '0);
      return e;
   endfunction

   // One clock cycle: drive at posedge+1, check and advance the model at negedge.
   task automatic step();
      logic [1:0] exp_rr;
      logic [1:0] exp_rv;
      logic       g;
      exp_t       e;
      req_valid = {(q1.size() > 0), (q0.size() > 0)};
      if (q0.size() > 0) begin
         req_a0 = q0[0].a; req_b0 = q0[0].b; req_op0 = q0[0].op;
      end else begin
         req_a0 = $urandom; req_b0 = $urandom; req_op0 = 3'($urandom);
      end
      if (q1.size() > 0) begin
         req_a1 = q1[0].a; req_b1 = q1[0].b; req_op1 = q1[0].op;
      end else begin
         req_a1 = $urandom; req_b1 = $urandom; req_op1 = 3'($urandom);
      end
      resp_ready = {(stall_left == 0), 1'b1};
      @(negedge clk);
      g = m_prio;
      if (req_valid == 2'b01) g = 1'b0;
      else if (req_valid == 2'b10) g = 1'b1;
      exp_rr = (m_state == M_IDLE && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (m_state == M_RESP) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      check("busy", 32'(busy), 32'(m_state != M_IDLE));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (m_state == M_RESP && sb.size() > 0) begin
         e = sb[0];
         check("resp_result", resp_result, e.result);
         check("resp_zero", 32'(resp_zero), 32'(e.zero));
         check("resp_err", 32'(resp_err), 32'(e.err));
      end
      case (m_state)
         M_IDLE: begin
            if (req_valid != 2'b00) begin
               if (g) begin
                  sb.push_back(alu_model(q1[0]));
                  void'(q1.pop_front());
               end else begin
                  sb.push_back(alu_model(q0[0]));
                  void'(q0.pop_front());
               end
               grants.push_back(int'(g));
               m_owner = g;
               m_prio  = ~g;
               m_state = M_EXEC;
            end
         end
         M_EXEC: m_state = M_RESP;
         default: begin
            if (resp_ready[m_owner]) begin
               if (sb.size() > 0) void'(sb.pop_front());
               m_state = M_IDLE;
            end else if (m_owner && stall_left > 0) begin
               stall_left--;
            end
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic run_all(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_state != M_IDLE) && n < budget) begin
         step();
         n++;
      end
      check("drain_in_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      sb.delete();
      grants.delete();
      m_state    = M_IDLE;
      m_prio     = 1'b0;
      stall_left = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_resp_result"}, resp_result, 32'd0);
      check({tag, "_resp_zero"}, 32'(resp_zero), 32'd0);
      check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b11;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      req_op0 = '0; req_op1 = '0;
      do_reset();

      // Single op from requester 0: 5 - 3.
      q0.push_back(mk(32'd5, 32'd3, OP_SUB));
      run_all(20);

      // Contention: both requesters valid continuously, grants must alternate.
      do_reset();
      q0.push_back(mk(32'd1, 32'd1, OP_ADD));
      q0.push_back(mk(32'd1, 32'd1, OP_ADD));
      q1.push_back(mk(32'hF0, 32'h0F, OP_AND));
      q1.push_back(mk(32'hF0, 32'h0F, OP_AND));
      run_all(40);
      check("grant_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < grants.size() && i < 4; i++) begin
         check($sformatf("grant_%0d", i), 32'(grants[i]), 32'(i % 2));
      end

      // Backpressure on requester 1 while requester 0 waits.
      q1.push_back(mk(32'd2, 32'd7, OP_SLT));
      stall_left = 4;
      step();
      q0.push_back(mk(32'hFFFF0000, 32'h00FF00FF, OP_ROR));
      run_all(40);

      // Illegal opcode, remaining opcodes and wraparound.
      q0.push_back(mk(32'd7, 32'd9, OP_ILL));
      q1.push_back(mk(32'hFFFF0000, 32'h00FF00FF, OP_RAND));
      q1.push_back(mk(32'hFFFFFFFF, 32'd1, OP_ADD));
      q0.push_back(mk(32'd7, 32'd2, OP_SLT));
      q0.push_back(mk(32'h12340000, 32'h00005678, OP_OR));
      run_all(80);

      // Reset while requester 1's response is stalled in RESP.
      q1.push_back(mk(32'd1, 32'd2, OP_OR));
      stall_left = 100;
      n = 0;
      while (m_state != M_RESP && n < 20) begin
         step();
         n++;
      end
      check("reached_resp", 32'(m_state == M_RESP), 32'd1);
      check("pre_reset_resp_valid", 32'(resp_valid), 32'd2);
      #2 resetn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_clear();
      req_valid = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
      q0.push_back(mk(32'd10, 32'd4, OP_SUB));
      run_all(20);
      check("post_reset_first_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
      q0.push_back(mk(32'd3, 32'd3, OP_SUB));
      q1.push_back(mk(32'd8, 32'd8, OP_ADD));
      run_all(40);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
